// File: rtl/mc_control_seq.sv
// mc_control_seq: multi-cycle IF/ID/EX/MEM/WB stage sequencer for the TSC datapath.
// Memory is accessed via a req/ready handshake with an optional wait timeout.
//
// Ports:
//   clk, reset        : clock; synchronous active-high reset
//   opcode, func_code : IR[15:12], IR[5:0] of the instruction held in IR
//   alu_compare       : ALU comparison result (SAME/BIG/SMALL)
//   mem_ready         : memory completes the current request this cycle
//   stage             : current stage code
//   mem_req, mem_we   : memory request and write qualifier
//   ir_write, pc_write, reg_write : datapath write enables
//   retire            : one-cycle pulse per completed instruction
//   output_active     : WWD in ID
//   illegal           : one-cycle pulse for an undefined encoding in ID
//   is_halted         : level, HALT state (HLT or memory error)
//   mem_err           : sticky memory timeout flag
//   inst_count        : retired-instruction counter (wraps)
//
// All outputs are combinational decodes of state and inputs, forced to 0
// while reset is high.

module mc_control_seq #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       opcode,
    input  logic [5:0]       func_code,
    input  logic [1:0]       alu_compare,
    input  logic             mem_ready,
    output logic [2:0]       stage,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             retire,
    output logic             output_active,
    output logic             illegal,
    output logic             is_halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] inst_count
);

    // Opcode encodings
    localparam logic [3:0] OP_BNE   = 4'd0;
    localparam logic [3:0] OP_BEQ   = 4'd1;
    localparam logic [3:0] OP_BGZ   = 4'd2;
    localparam logic [3:0] OP_BLZ   = 4'd3;
    localparam logic [3:0] OP_LWD   = 4'd7;
    localparam logic [3:0] OP_SWD   = 4'd8;
    localparam logic [3:0] OP_JMP   = 4'd9;
    localparam logic [3:0] OP_JAL   = 4'd10;
    localparam logic [3:0] OP_RTYPE = 4'd15;

    // R-type function encodings; ALU funcs occupy 0..FN_LAST_ALU
    localparam logic [5:0] FN_LAST_ALU = 6'd7;
    localparam logic [5:0] FN_JPR      = 6'd25;
    localparam logic [5:0] FN_JRL      = 6'd26;
    localparam logic [5:0] FN_WWD      = 6'd28;
    localparam logic [5:0] FN_HLT      = 6'd29;

    // ALU comparison encodings
    localparam logic [1:0] ALU_SAME  = 2'b00;
    localparam logic [1:0] ALU_BIG   = 2'b01;
    localparam logic [1:0] ALU_SMALL = 2'b10;

    localparam int unsigned WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    // State encoding doubles as the externally visible stage code
    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               mem_err_q, mem_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               is_branch, br_taken, is_mem_op, is_swd;
    logic               is_jump, is_link, is_wwd, is_hlt, is_illegal;

    logic               raw_mem_req, raw_mem_we, raw_ir_write, raw_pc_write;
    logic               raw_reg_write, raw_retire, raw_output_active, raw_illegal;

    logic [WAIT_W-1:0]  wait_inc;
    logic               timeout_hit;

    // Instruction class decode from the current IR fields
    always_comb begin
        is_branch  = 1'b0;
        br_taken   = 1'b0;
        is_mem_op  = 1'b0;
        is_swd     = 1'b0;
        is_jump    = 1'b0;
        is_link    = 1'b0;
        is_wwd     = 1'b0;
        is_hlt     = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_BNE: begin
                is_branch = 1'b1;
                br_taken  = (alu_compare != ALU_SAME);
            end
            OP_BEQ: begin
                is_branch = 1'b1;
                br_taken  = (alu_compare == ALU_SAME);
            end
            OP_BGZ: begin
                is_branch = 1'b1;
                br_taken  = (alu_compare == ALU_BIG);
            end
            OP_BLZ: begin
                is_branch = 1'b1;
                br_taken  = (alu_compare == ALU_SMALL);
            end
            OP_LWD: is_mem_op = 1'b1;
            OP_SWD: begin
                is_mem_op = 1'b1;
                is_swd    = 1'b1;
            end
            OP_JMP: is_jump = 1'b1;
            OP_JAL: begin
                is_jump = 1'b1;
                is_link = 1'b1;
            end
            4'd11, 4'd12, 4'd13, 4'd14: is_illegal = 1'b1;
            OP_RTYPE: begin
                case (func_code)
                    FN_JPR: is_jump = 1'b1;
                    FN_JRL: begin
                        is_jump = 1'b1;
                        is_link = 1'b1;
                    end
                    FN_WWD:  is_wwd = 1'b1;
                    FN_HLT:  is_hlt = 1'b1;
                    default: is_illegal = (func_code > FN_LAST_ALU);
                endcase
            end
            default: ; // ADI / ORI / LHI: plain ALU-immediate path
        endcase
    end

    // A wait cycle that would bring the counter to TIMEOUT ends the access;
    // mem_ready in that same cycle takes priority because it is tested first.
    assign wait_inc    = wait_q + WAIT_W'(1);
    assign timeout_hit = (TIMEOUT != 0) && (wait_inc == WAIT_W'(TIMEOUT));

    // Next-state and raw output decode
    always_comb begin
        state_d           = state_q;
        wait_d            = '0;
        mem_err_d         = mem_err_q;
        raw_mem_req       = 1'b0;
        raw_mem_we        = 1'b0;
        raw_ir_write      = 1'b0;
        raw_pc_write      = 1'b0;
        raw_reg_write     = 1'b0;
        raw_retire        = 1'b0;
        raw_output_active = 1'b0;
        raw_illegal       = 1'b0;

        case (state_q)
            ST_IF: begin
                raw_mem_req = 1'b1;
                if (mem_ready) begin
                    raw_ir_write = 1'b1;
                    raw_pc_write = 1'b1;
                    state_d      = ST_ID;
                end else if (timeout_hit) begin
                    mem_err_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    wait_d = wait_inc;
                end
            end
            ST_ID: begin
                if (is_illegal) begin
                    raw_illegal = 1'b1;
                    state_d     = ST_IF;
                end else if (is_jump) begin
                    raw_pc_write  = 1'b1;
                    raw_reg_write = is_link;
                    raw_retire    = 1'b1;
                    state_d       = ST_IF;
                end else if (is_wwd) begin
                    raw_output_active = 1'b1;
                    raw_retire        = 1'b1;
                    state_d           = ST_IF;
                end else if (is_hlt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EX;
                end
            end
            ST_EX: begin
                if (is_branch) begin
                    raw_pc_write = br_taken;
                    raw_retire   = 1'b1;
                    state_d      = ST_IF;
                end else if (is_mem_op) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                raw_mem_req = 1'b1;
                raw_mem_we  = is_swd;
                if (mem_ready) begin
                    if (is_swd) begin
                        raw_retire = 1'b1;
                        state_d    = ST_IF;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timeout_hit) begin
                    mem_err_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    wait_d = wait_inc;
                end
            end
            ST_WB: begin
                raw_reg_write = 1'b1;
                raw_retire    = 1'b1;
                state_d       = ST_IF;
            end
            ST_HALT: ; // parked until reset
            default: state_d = ST_IF;
        endcase
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W
    assign cnt_d = raw_retire ? (cnt_q + CNT_W'(1)) : cnt_q;

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IF;
            wait_q    <= '0;
            mem_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            mem_err_q <= mem_err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Outputs forced low during reset so a reset mid-access drops the request at once
    assign stage         = reset ? 3'd0 : state_q;
    assign mem_req       = raw_mem_req       & ~reset;
    assign mem_we        = raw_mem_we        & ~reset;
    assign ir_write      = raw_ir_write      & ~reset;
    assign pc_write      = raw_pc_write      & ~reset;
    assign reg_write     = raw_reg_write     & ~reset;
    assign retire        = raw_retire        & ~reset;
    assign output_active = raw_output_active & ~reset;
    assign illegal       = raw_illegal       & ~reset;
    assign is_halted     = (state_q == ST_HALT) & ~reset;
    assign mem_err       = mem_err_q         & ~reset;
    assign inst_count    = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_mc_control_seq.sv
// Testbench for mc_control_seq (CNT_W=4, TIMEOUT=4). A driver expands each
// instruction into per-cycle expected outputs from the stage/latency rules and
// queues them; a monitor pops one entry per cycle and compares.

module tb_mc_control_seq;

    localparam int unsigned CNT_W_P   = 4;
    localparam int unsigned TIMEOUT_P = 4;

    localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2,
                           S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;

    localparam int C_ALU = 0, C_BR = 1, C_LD = 2, C_ST = 3, C_JMP = 4,
                   C_LINK = 5, C_WWD = 6, C_HLT = 7, C_ILL = 8;

    typedef struct packed {
        logic [2:0]         stage;
        logic               mem_req;
        logic               mem_we;
        logic               ir_write;
        logic               pc_write;
        logic               reg_write;
        logic               retire;
        logic               output_active;
        logic               illegal;
        logic               is_halted;
        logic               mem_err;
        logic [CNT_W_P-1:0] inst_count;
    } obs_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [3:0]         opcode = 4'd0;
    logic [5:0]         func_code = 6'd0;
    logic [1:0]         alu_compare = 2'd0;
    logic               mem_ready = 1'b0;
    logic [2:0]         stage;
    logic               mem_req, mem_we, ir_write, pc_write, reg_write, retire;
    logic               output_active, illegal, is_halted, mem_err;
    logic [CNT_W_P-1:0] inst_count;

    mc_control_seq #(.CNT_W(CNT_W_P), .TIMEOUT(TIMEOUT_P)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .func_code(func_code),
        .alu_compare(alu_compare), .mem_ready(mem_ready), .stage(stage),
        .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .retire(retire),
        .output_active(output_active), .illegal(illegal),
        .is_halted(is_halted), .mem_err(mem_err), .inst_count(inst_count)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;

    // Reference model state
    int   m_cnt  = 0;
    bit   m_err  = 1'b0;
    bit   m_halt = 1'b0;

    // Monitor: one expected snapshot per driven cycle
    always @(negedge clk) begin
        obs_t a, e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.stage = stage; a.mem_req = mem_req; a.mem_we = mem_we;
            a.ir_write = ir_write; a.pc_write = pc_write; a.reg_write = reg_write;
            a.retire = retire; a.output_active = output_active; a.illegal = illegal;
            a.is_halted = is_halted; a.mem_err = mem_err; a.inst_count = inst_count;
            n_total++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL obs cycle=%0d got=%b required=%b (stage,req,we,ir,pc,rw,ret,out,ill,halt,err,cnt)",
                         cyc, a, e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    function automatic int classify(input logic [3:0] op, input logic [5:0] fn);
        if (op <= 4'd3) return C_BR;
        if (op <= 4'd6) return C_ALU;
        if (op == 4'd7) return C_LD;
        if (op == 4'd8) return C_ST;
        if (op == 4'd9) return C_JMP;
        if (op == 4'd10) return C_LINK;
        if (op <= 4'd14) return C_ILL;
        if (fn <= 6'd7) return C_ALU;
        if (fn == 6'd25) return C_JMP;
        if (fn == 6'd26) return C_LINK;
        if (fn == 6'd28) return C_WWD;
        if (fn == 6'd29) return C_HLT;
        return C_ILL;
    endfunction

    // BNE/BEQ/BGZ/BLZ with SAME=0, BIG=1, SMALL=2
    function automatic logic taken(input logic [3:0] op, input logic [1:0] cmp);
        case (op)
            4'd0:    return cmp != 2'd0;
            4'd1:    return cmp == 2'd0;
            4'd2:    return cmp == 2'd1;
            default: return cmp == 2'd2;
        endcase
    endfunction

    function automatic obs_t obs(input logic [2:0] st);
        obs_t e;
        e = '0;
        e.stage      = st;
        e.is_halted  = (st == S_HALT);
        e.mem_err    = m_err;
        e.inst_count = CNT_W_P'(m_cnt);
        return e;
    endfunction

    task automatic bump();
        m_cnt = (m_cnt + 1) % (1 << CNT_W_P);
    endtask

    task automatic step(input obs_t e, input logic rdy, input logic rst,
                        input logic [3:0] op, input logic [5:0] fn, input logic [1:0] cmp);
        @(posedge clk);
        #1;
        reset = rst; mem_ready = rdy; opcode = op; func_code = fn; alu_compare = cmp;
        exp_q.push_back(e);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++)
            step('0, rbit(), 1'b1, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)),
                 2'($urandom_range(0, 3)));
        m_cnt = 0; m_err = 1'b0; m_halt = 1'b0;
    endtask

    task automatic hold_halt(input int n);
        for (int i = 0; i < n; i++)
            step(obs(S_HALT), rbit(), 1'b0, 4'($urandom_range(0, 15)),
                 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)));
    endtask

    // Expand one instruction into expected cycles. rst_at: MEM cycle index at
    // which reset is asserted (-1 for none).
    task automatic run_instr(input logic [3:0] op, input logic [5:0] fn, input logic [1:0] cmp,
                             input int if_wait, input int mem_wait, input int rst_at);
        obs_t e;
        logic rdy;
        int   cls;
        cls = classify(op, fn);
        for (int w = 0; w <= if_wait; w++) begin
            rdy = (w == if_wait);
            e = obs(S_IF);
            e.mem_req = 1'b1;
            if (rdy) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
            step(e, rdy, 1'b0, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)),
                 2'($urandom_range(0, 3)));
            if (!rdy && (w + 1) == TIMEOUT_P) begin m_err = 1'b1; m_halt = 1'b1; return; end
        end
        e = obs(S_ID);
        case (cls)
            C_JMP:  begin e.pc_write = 1'b1; e.retire = 1'b1; end
            C_LINK: begin e.pc_write = 1'b1; e.reg_write = 1'b1; e.retire = 1'b1; end
            C_WWD:  begin e.output_active = 1'b1; e.retire = 1'b1; end
            C_ILL:  e.illegal = 1'b1;
            default: ;
        endcase
        step(e, rbit(), 1'b0, op, fn, 2'($urandom_range(0, 3)));
        if (e.retire) bump();
        if (cls == C_HLT) m_halt = 1'b1;
        if (cls >= C_JMP) return;
        e = obs(S_EX);
        if (cls == C_BR) begin e.pc_write = taken(op, cmp); e.retire = 1'b1; end
        step(e, rbit(), 1'b0, op, fn, cmp);
        if (cls == C_BR) begin bump(); return; end
        if (cls == C_LD || cls == C_ST) begin
            for (int w = 0; w <= mem_wait; w++) begin
                if (w == rst_at) begin
                    step('0, 1'b0, 1'b1, op, fn, cmp);
                    m_cnt = 0; m_err = 1'b0; m_halt = 1'b0;
                    return;
                end
                rdy = (w == mem_wait);
                e = obs(S_MEM);
                e.mem_req = 1'b1;
                e.mem_we  = (cls == C_ST);
                if (rdy && cls == C_ST) e.retire = 1'b1;
                step(e, rdy, 1'b0, op, fn, 2'($urandom_range(0, 3)));
                if (!rdy && (w + 1) == TIMEOUT_P) begin m_err = 1'b1; m_halt = 1'b1; return; end
            end
            if (cls == C_ST) begin bump(); return; end
        end
        e = obs(S_WB);
        e.reg_write = 1'b1;
        e.retire    = 1'b1;
        step(e, rbit(), 1'b0, op, fn, 2'($urandom_range(0, 3)));
        bump();
    endtask

    task automatic recover_if_halted();
        if (m_halt) begin
            hold_halt(int'($urandom_range(1, 4)));
            do_reset(1);
        end
    endtask

    initial begin
        logic [5:0] fn_list [12];
        logic [3:0] op;
        logic [5:0] fn;
        int         iw, mw;
        fn_list = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
                    6'd25, 6'd26, 6'd28, 6'd29};

        do_reset(3);

        // Directed cases
        run_instr(4'd15, 6'd0, 2'd0, 0, 0, -1);          // ADD, no waits
        run_instr(4'd7,  6'd0, 2'd0, 0, 3, -1);          // LWD, 3 MEM waits
        run_instr(4'd1,  6'd0, 2'd0, 0, 0, -1);          // BEQ SAME: taken
        run_instr(4'd1,  6'd0, 2'd1, 0, 0, -1);          // BEQ BIG: not taken
        run_instr(4'd12, 6'd0, 2'd0, 0, 0, -1);          // illegal opcode
        run_instr(4'd15, 6'd40, 2'd0, 1, 0, -1);         // illegal R-type func
        for (int i = 0; i < 16; i++)
            run_instr(4'd15, 6'd28, 2'd0, 0, 0, -1);     // WWD x16: counter wrap
        run_instr(4'd10, 6'd0, 2'd0, 2, 0, -1);          // JAL
        run_instr(4'd15, 6'd26, 2'd0, 0, 0, -1);         // JRL
        run_instr(4'd8,  6'd0, 2'd0, 3, 3, -1);          // SWD, ready on last allowed wait
        run_instr(4'd15, 6'd29, 2'd0, 0, 0, -1);         // HLT
        hold_halt(20);
        do_reset(1);
        run_instr(4'd4,  6'd0, 2'd0, 10, 0, -1);         // IF timeout
        hold_halt(3);
        do_reset(2);
        run_instr(4'd7,  6'd0, 2'd0, 0, 9, -1);          // MEM timeout
        hold_halt(3);
        do_reset(1);
        run_instr(4'd15, 6'd28, 2'd0, 0, 0, -1);
        run_instr(4'd8,  6'd0, 2'd0, 0, 3, 1);           // reset mid-SWD
        run_instr(4'd6,  6'd0, 2'd0, 0, 0, -1);          // LHI after reset

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) fn = 6'($urandom_range(0, 63));
            else fn = fn_list[$urandom_range(0, 11)];
            iw = ($urandom_range(0, 19) == 0) ? 6 : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 19) == 0) ? 6 : int'($urandom_range(0, 3));
            run_instr(op, fn, 2'($urandom_range(0, 3)), iw, mw,
                      ($urandom_range(0, 49) == 0) ? 0 : -1);
            recover_if_halted();
        end

        @(negedge clk);
        #1;
        n_total++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got=%0d pending entries required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_control_seq.md
# mc_control_seq

Multi-cycle stage sequencer for the TSC CPU datapath, and the successor to the fixed-latency control unit. It drives the IF/ID/EX/MEM/WB stage machine from the fetched opcode and function code. Memory is accessed through a req/ready handshake, so any number of wait states is supported. It adds a parametrised memory timeout with a sticky error, a retired-instruction counter and illegal-instruction flagging.

## Interface
Parameters:
- CNT_W, 16: width of the retired-instruction counter.
- TIMEOUT, 0: number of wait cycles without mem_ready before a memory error. 0 disables the timeout.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  4  IR[15:12]; `OPCODE_*` encodings from opcodes.v (R-type = 15).
- func_code  in  6  IR[5:0]; `FUNC_*` encodings.
- alu_compare  in  2  ALU comparison result, encoded as `ALU_SAME` / `ALU_BIG` / `ALU_SMALL`.
- mem_ready  in  1  memory completed the current request this cycle.
- stage  out  3  current `STAGE_*` code.
- mem_req, mem_we  out  1  memory request; write qualifier.
- ir_write, pc_write, reg_write  out  1  datapath write enables.
- retire  out  1  one-cycle pulse when an instruction completes.
- output_active  out  1  WWD in ID.
- illegal  out  1  one-cycle pulse when an undefined encoding is in ID.
- is_halted  out  1  level, set by HLT or mem_err.
- mem_err  out  1  sticky timeout flag.
- inst_count  out  CNT_W  retired-instruction count.

## Operation
States: IF, ID, EX, MEM, WB, HALT. All outputs are decoded combinationally from state and inputs, then gated to 0 while reset is high.

IF:
- mem_req=1, mem_we=0.
- Holds while mem_ready=0.
- In the cycle mem_ready=1: ir_write=1 and pc_write=1 (PC+1), then go to ID.

ID:
- JMP(9), JAL(10), JPR(15/25), JRL(15/26): pc_write=1; reg_write=1 for JAL and JRL; retire; go to IF.
- WWD(15/28): output_active=1, retire, go to IF.
- HLT(15/29): go to HALT. HLT does not retire.
- Opcodes 11–14, or an R-type func outside the ISA: illegal=1, no writes, no retire, go to IF.
- All other instructions go to EX.

EX:
- Branch BNE(0), BEQ(1), BGZ(2), BLZ(3): pc_write=1 only if taken (BNE: not SAME; BEQ: SAME; BGZ: BIG; BLZ: SMALL); retire; go to IF.
- LWD(7), SWD(8): go to MEM.
- Everything else goes to WB.

MEM:
- mem_req=1; mem_we=1 only for SWD.
- Holds while mem_ready=0.
- On mem_ready: LWD goes to WB; SWD retires and goes to IF.

WB: reg_write=1, retire, go to IF.

HALT:
- is_halted=1; all enables are 0.
- Only reset exits.

Timeout:
- A wait counter is cleared on entry to IF or MEM and on mem_ready.
- It increments every IF/MEM cycle with mem_ready=0.
- If TIMEOUT>0 and the counter reaches TIMEOUT: mem_err←1, go to HALT, no ir_write or retire for that access.
- mem_err clears only on reset.

inst_count increments by 1 on each retire and wraps from 2^CNT_W−1 to 0.

## Timing
Reset values:
- stage = IF; all enables, retire, illegal and output_active = 0.
- is_halted = 0, mem_err = 0, inst_count = 0.
- The first fetch request appears in the cycle after reset deasserts.

Minimum latency with zero wait states (mem_ready high in the first cycle):
- 2 cycles: jumps, WWD.
- 3 cycles: branches.
- 4 cycles: ALU ops and ADI/ORI/LHI.
- 4 cycles: SWD.
- 5 cycles: LWD.
- Each wait cycle adds 1.

Handshake rules:
- mem_req stays high and constant until the mem_ready cycle and drops in the next cycle, unless the next state is also a memory state.
- mem_ready outside IF/MEM is ignored.

Boundary conditions:
- mem_ready and the timeout reaching TIMEOUT in the same cycle: mem_ready wins, and the access completes normally.
- Reset mid-MEM: mem_req and mem_we drop in that same cycle, and the state is IF next cycle.
- retire and the inst_count wrap in the same cycle: the counter reads 0 next cycle.

## Test plan
- ADD (opcode 15, func 0), mem_ready always 1 → stages IF,ID,EX,WB; reg_write only in cycle 4; retire pulse; inst_count 0→1.
- LWD (opcode 7) with mem_ready delayed 3 cycles in MEM → mem_req high 4 consecutive MEM cycles, mem_we=0; WB follows; total 8 cycles.
- BEQ (opcode 1): alu_compare=`ALU_SAME` → pc_write in EX; alu_compare=`ALU_BIG` → no pc_write in EX. Both cases retire after 3 cycles.
- TIMEOUT=4, IF with mem_ready held 0 → mem_err=1 and is_halted=1 after 4 wait cycles, no ir_write; mem_req=0 in HALT; reset clears everything.
- HLT (15/29) → is_halted from the cycle after ID, and it holds for 20 cycles; opcode 12 → illegal pulse, no retire, back to IF.
- CNT_W=4, 16 WWDs → inst_count wraps 15→0; reset asserted mid-SWD → mem_we=0 in the reset cycle, stage=IF after.
